nfc_cmd_arbiter: RTL and testbench
==================================

NFC_CMD_ARBITER -- requirements
Module: nfc_cmd_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 2, number of command requesters sharing one NFC channel (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2^24-1, WAIT_DONE watchdog limit in clk cycles (>=1).
REQ-003 SHALL have ports as follows; one clock; reset is synchronous and active-high:
  clk  in  1  single clock, shared with the channel command port.
  rst  in  1  synchronous, active-high reset.
  req_valid  in  REQ_NUM  per-requester command valid.
  req_ready  out  REQ_NUM  one-cycle accept pulse per requester.
  req_opc  in  16*REQ_NUM  packed opcodes, requester i at [16i+15:16i].
  req_lba  in  48*REQ_NUM  packed logical block addresses.
  req_len  in  24*REQ_NUM  packed byte lengths.
  req_done  out  REQ_NUM  one-cycle completion pulse to the owning requester.
  req_err  out  1  qualifies req_done: 1 = watchdog timeout.
  req_sr  out  8  channel status byte captured at completion.
  o_valid  out  1  channel command valid.
  i_ready  in  1  channel command ready.
  o_opc / o_lba / o_len  out  16/48/24  command issued to the channel.
  i_done  in  1  channel completion pulse.
  i_sr  in  8  channel status register.
  o_busy  out  1  1 whenever state != IDLE.
  o_grant  out  $clog2(REQ_NUM)  index of current owner.

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE, plus WAIT_DONE -> IDLE on timeout.
REQ-005 In IDLE with any req_valid set, SHALL select the first set bit searching round-robin from pointer rr_ptr upward with wrap at REQ_NUM-1 -> 0.
REQ-006 Upon selection, same cycle: req_ready[sel]=1 for exactly one cycle; opc/lba/len of sel latched into output registers; o_grant<=sel; next state ISSUE.
REQ-007 In ISSUE, o_valid SHALL be 1 with stable o_opc/o_lba/o_len until the cycle i_ready=1; that cycle -> WAIT_DONE, o_valid deasserts next cycle.
REQ-008 i_done SHALL be sampled only in WAIT_DONE; i_done in IDLE/ISSUE ignored.
REQ-009 In WAIT_DONE on i_done=1: next cycle req_done[o_grant]=1 for one cycle, req_err=0, req_sr=i_sr sampled in the i_done cycle; rr_ptr<=(o_grant+1) mod REQ_NUM; state IDLE.
REQ-010 Watchdog counter (24-bit) SHALL clear on entering WAIT_DONE, increment each WAIT_DONE cycle; on reaching TIMEOUT_CYCLES without i_done: req_done[o_grant]=1, req_err=1, req_sr=8'hFF, rr_ptr advanced, state IDLE.
REQ-011 i_done in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (normal completion, req_err=0).
REQ-012 Minimum turnaround: done pulse cycle -> IDLE; next command acceptable the cycle after done; no back-to-back acceptance within one command.
REQ-013 Requester withdrawing req_valid before selection SHALL not be granted; command content is sampled only in the accept cycle.
REQ-014 Only one requester SHALL ever see req_ready or req_done per cycle; at most one command outstanding on the channel.

Reset
REQ-015 On rst=1: state IDLE, rr_ptr=0, o_grant=0, o_valid=0, req_ready=0, req_done=0, req_err=0, req_sr=0, o_opc/o_lba/o_len=0, counter=0, o_busy=0.
REQ-016 Reset mid-ISSUE or mid-WAIT_DONE SHALL abandon the command with no req_done pulse; channel reset is the system's responsibility.

Structure
REQ-017 FSM state encoding, opcode/LBA/length widths (16/48/24) and timeout status code 8'hFF SHALL live in shared package nfc_pkg.
REQ-018 Round-robin selection SHALL be a sub-module nfc_rr_pick (input valid vector + pointer, output index + found), purely combinational.

Verification
REQ-019 Single requester 0: opc=16'h0080, lba=48'h1, len=24'h1000; i_ready after 3 cycles, i_done 20 cycles later with i_sr=8'hE0 -> one req_ready[0], o_valid 4 cycles, req_done[0] with req_sr=8'hE0, req_err=0.
REQ-020 Both requesters valid continuously, rr_ptr=0 -> grant order 0,1,0,1 over four commands; never two grants without an intervening req_done.
REQ-021 TIMEOUT_CYCLES=16, no i_done -> req_done pulse 16 cycles after WAIT_DONE entry, req_err=1, req_sr=8'hFF, next grant goes to the other requester.
REQ-022 i_done coincident with timeout terminal count -> req_err=0, req_sr=i_sr.
REQ-023 rst asserted in WAIT_DONE, then i_done pulse -> no req_done, o_busy=0, all outputs at reset values; next command from requester 0 proceeds normally.
REQ-024 i_done pulsed during ISSUE (before i_ready) -> ignored; completion only on subsequent WAIT_DONE i_done.

Source files
------------

// File: rtl/nfc_pkg.sv
// Shared types and constants for the NFC command arbiter.
package nfc_pkg;

  localparam int OPC_W = 16;
  localparam int LBA_W = 48;
  localparam int LEN_W = 24;
  localparam int CNT_W = 24;

  // Status byte reported to the requester when the channel never completed.
  localparam logic [7:0] SR_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nfc_rr_pick.sv
// Combinational round-robin picker: first set bit at or above ptr, wrapping to 0.
module nfc_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (valid[j[W-1:0]]) begin
        found = 1'b1;
        idx   = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/nfc_cmd_arbiter.sv
// Round-robin arbiter sharing one NFC channel command port among REQ_NUM requesters,
// with a watchdog on the channel completion.
module nfc_cmd_arbiter
  import nfc_pkg::*;
#(
  parameter int REQ_NUM        = 2,
  parameter int TIMEOUT_CYCLES = (1 << 24) - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_NUM-1:0]           req_valid,
  output logic [REQ_NUM-1:0]           req_ready,
  input  logic [16*REQ_NUM-1:0]        req_opc,
  input  logic [48*REQ_NUM-1:0]        req_lba,
  input  logic [24*REQ_NUM-1:0]        req_len,
  output logic [REQ_NUM-1:0]           req_done,
  output logic                         req_err,
  output logic [7:0]                   req_sr,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [15:0]                  o_opc,
  output logic [47:0]                  o_lba,
  output logic [23:0]                  o_len,
  input  logic                         i_done,
  input  logic [7:0]                   i_sr,
  output logic                         o_busy,
  output logic [$clog2(REQ_NUM)-1:0]   o_grant
);

  localparam int GW = $clog2(REQ_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [GW-1:0]    rr_ptr, pick_idx, grant_next;
  logic             pick_found;
  logic [CNT_W-1:0] cnt;
  logic             accept, issue_go, done_ok, done_to;

  nfc_rr_pick #(.N(REQ_NUM), .W(GW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Handshakes: a requester command transfers in the cycle req_valid[i] && req_ready[i];
  // the channel command transfers in the cycle o_valid && i_ready.
  assign accept     = (state == ST_IDLE) && pick_found && !rst;
  assign issue_go   = (state == ST_ISSUE) && i_ready;
  assign done_ok    = (state == ST_WAIT_DONE) && i_done;
  // A completion arriving on the terminal count takes priority over the timeout.
  assign done_to    = (state == ST_WAIT_DONE) && !i_done && (cnt == CNT_LAST);
  assign grant_next = (o_grant == GW'(REQ_NUM - 1)) ? '0 : o_grant + 1'b1;

  assign req_ready  = accept ? (REQ_NUM'(1) << pick_idx) : '0;
  assign o_valid    = (state == ST_ISSUE);
  assign o_busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE:     if (issue_go) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_ok || done_to) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      o_grant  <= '0;
      o_opc    <= '0;
      o_lba    <= '0;
      o_len    <= '0;
      cnt      <= '0;
      req_done <= '0;
      req_err  <= 1'b0;
      req_sr   <= '0;
    end else begin
      req_done <= '0;
      if (accept) begin
        o_grant <= pick_idx;
        o_opc   <= req_opc[OPC_W*int'(pick_idx) +: OPC_W];
        o_lba   <= req_lba[LBA_W*int'(pick_idx) +: LBA_W];
        o_len   <= req_len[LEN_W*int'(pick_idx) +: LEN_W];
      end
      if (issue_go) cnt <= '0;
      else if (state == ST_WAIT_DONE) cnt <= cnt + 1'b1;
      if (done_ok || done_to) begin
        req_done <= REQ_NUM'(1) << o_grant;
        req_err  <= done_to;
        req_sr   <= done_ok ? i_sr : SR_TIMEOUT;
        rr_ptr   <= grant_next;
      end
    end
  end

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// Scoreboard bench for nfc_cmd_arbiter: grant and completion expectations are queued
// as stimulus is driven and popped by a negedge monitor.
module tb_nfc_cmd_arbiter;

  localparam int N    = 2;
  localparam int TO   = 16;
  localparam int TO_L = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_opc = '0;
  logic [48*N-1:0] req_lba = '0;
  logic [24*N-1:0] req_len = '0;
  logic            i_ready = 1'b0;
  logic            i_done = 1'b0;
  logic [7:0]      i_sr = '0;

  logic [N-1:0] req_ready, req_done, l_req_ready, l_req_done;
  logic         req_err, o_valid, o_busy, l_req_err, l_o_valid, l_o_busy;
  logic [7:0]   req_sr, l_req_sr;
  logic [15:0]  o_opc, l_o_opc;
  logic [47:0]  o_lba, l_o_lba;
  logic [23:0]  o_len, l_o_len;
  logic [0:0]   o_grant, l_o_grant;

  nfc_cmd_arbiter #(.REQ_NUM(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opc(req_opc), .req_lba(req_lba), .req_len(req_len),
    .req_done(req_done), .req_err(req_err), .req_sr(req_sr),
    .o_valid(o_valid), .i_ready(i_ready), .o_opc(o_opc), .o_lba(o_lba), .o_len(o_len),
    .i_done(i_done), .i_sr(i_sr), .o_busy(o_busy), .o_grant(o_grant)
  );

  // Long-watchdog instance on the same inputs, checked only in the first scenario.
  nfc_cmd_arbiter #(.REQ_NUM(N), .TIMEOUT_CYCLES(TO_L)) dut_l (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l_req_ready),
    .req_opc(req_opc), .req_lba(req_lba), .req_len(req_len),
    .req_done(l_req_done), .req_err(l_req_err), .req_sr(l_req_sr),
    .o_valid(l_o_valid), .i_ready(i_ready), .o_opc(l_o_opc), .o_lba(l_o_lba), .o_len(l_o_len),
    .i_done(i_done), .i_sr(i_sr), .o_busy(l_o_busy), .o_grant(l_o_grant)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_busy"},    o_busy,    0);
    check({p, "_valid"},   o_valid,   0);
    check({p, "_grant"},   o_grant,   0);
    check({p, "_ready"},   req_ready, 0);
    check({p, "_done"},    req_done,  0);
    check({p, "_err"},     req_err,   0);
    check({p, "_sr"},      req_sr,    0);
    check({p, "_opc"},     o_opc,     0);
    check({p, "_lba"},     o_lba,     0);
    check({p, "_len"},     o_len,     0);
  endtask

  // ---------------- scoreboard ----------------
  logic [90:0] grant_q[$];   // {idx[2:0], opc, lba, len}
  logic [19:0] done_q[$];    // {idx[2:0], err, sr, latency}

  function automatic logic [90:0] cmd_rec(input int idx, input logic [15:0] opc,
                                          input logic [47:0] lba, input logic [23:0] len);
    return {3'(idx), opc, lba, len};
  endfunction

  function automatic logic [19:0] done_rec(input int idx, input logic err,
                                           input logic [7:0] sr, input int lat);
    return {3'(idx), err, sr, 8'(lat)};
  endfunction

  logic [90:0] cur_cmd = '0;
  logic        cmd_pending = 1'b0;
  logic        outstanding = 1'b0;
  int          wait_start = 0, l_wait_start = 0;
  int          ovalid_cnt = 0, l_ovalid_cnt = 0, l_done_cnt = 0;
  bit          chk_long = 1'b1;

  always @(negedge clk) begin
    logic [90:0] g;
    logic [19:0] d;
    if (rst) begin
      outstanding = 1'b0;
      cmd_pending = 1'b0;
    end else begin
      if (o_valid && i_ready) wait_start = cyc + 1;
      if (chk_long) begin
        if (o_valid) ovalid_cnt++;
        if (l_o_valid) l_ovalid_cnt++;
        if (l_o_valid && i_ready) l_wait_start = cyc + 1;
        if (l_req_done != '0) begin
          l_done_cnt++;
          check("l_done_vec", l_req_done, 2'b01);
          check("l_done_err", l_req_err, 0);
          check("l_done_sr", l_req_sr, 8'hE0);
          check("l_done_latency", cyc - l_wait_start, 20);
        end
      end
      if (req_done != '0) begin
        if (done_q.size() == 0) check("done_unexpected", req_done, 0);
        else begin
          d = done_q.pop_front();
          check("done_vec", req_done, N'(1) << d[19:17]);
          check("done_err", req_err, d[16]);
          check("done_sr", req_sr, d[15:8]);
          check("done_latency", cyc - wait_start, d[7:0]);
        end
        outstanding = 1'b0;
      end
      if (req_ready != '0) begin
        check("single_outstanding", outstanding, 0);
        if (grant_q.size() == 0) check("grant_unexpected", req_ready, 0);
        else begin
          g = grant_q.pop_front();
          check("ready_vec", req_ready, N'(1) << g[90:88]);
          cur_cmd     = g;
          cmd_pending = 1'b1;
        end
        outstanding = 1'b1;
      end else if (cmd_pending && o_valid) begin
        check("o_grant", o_grant, cur_cmd[90:88]);
        check("o_opc", o_opc, cur_cmd[87:72]);
        check("o_lba", o_lba, cur_cmd[71:24]);
        check("o_len", o_len, cur_cmd[23:0]);
        cmd_pending = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_cmd(input int i, input logic [15:0] opc, input logic [47:0] lba,
                         input logic [23:0] len);
    req_opc[16*i +: 16] = opc;
    req_lba[48*i +: 48] = lba;
    req_len[24*i +: 24] = len;
  endtask

  // Channel side: wait for o_valid, stall rdy_dly cycles, then optionally complete
  // with i_done done_dly cycles after the i_ready cycle.
  task automatic channel(input int rdy_dly, input int done_dly, input logic [7:0] sr,
                         input bit give_done, input bit early_done);
    int n;
    n = 0;
    while (!o_valid && n < 60) begin
      step();
      n++;
    end
    if (!o_valid) begin
      check("issue_wait", o_valid, 1);
      return;
    end
    for (int k = 0; k < rdy_dly; k++) begin
      i_done = early_done && (k == 1);
      step();
    end
    i_done  = 1'b0;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    if (give_done) begin
      repeat (done_dly - 1) step();
      i_done = 1'b1;
      i_sr   = sr;
      step();
      i_done = 1'b0;
      i_sr   = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single command; short watchdog times out, long one completes with E0.
    set_cmd(0, 16'h0080, 48'h1, 24'h1000);
    grant_q.push_back(cmd_rec(0, 16'h0080, 48'h1, 24'h1000));
    done_q.push_back(done_rec(0, 1'b1, 8'hFF, TO));
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    channel(3, 20, 8'hE0, 1'b1, 1'b0);
    repeat (3) step();
    check("t1_ovalid_cycles", ovalid_cnt, 4);
    check("t1_l_ovalid_cycles", l_ovalid_cnt, 4);
    check("t1_l_done_count", l_done_cnt, 1);
    chk_long = 1'b0;

    // Both requesters valid continuously from rr_ptr 0: order 0,1,0,1.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    set_cmd(0, 16'h0011, 48'h0000_0000_00A0, 24'h000200);
    set_cmd(1, 16'h0022, 48'h0000_0000_00B0, 24'h000400);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) grant_q.push_back(cmd_rec(0, 16'h0011, 48'hA0, 24'h200));
      else            grant_q.push_back(cmd_rec(1, 16'h0022, 48'hB0, 24'h400));
      done_q.push_back(done_rec(k % 2, 1'b0, 8'(8'h10 + k), 2));
    end
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) channel(1, 2, 8'(8'h10 + k), 1'b1, 1'b0);
    req_valid = '0;
    repeat (2) step();

    // Watchdog expiry, then the other requester wins the next arbitration.
    set_cmd(0, 16'h0033, 48'hC0, 24'h80);
    grant_q.push_back(cmd_rec(0, 16'h0033, 48'hC0, 24'h80));
    done_q.push_back(done_rec(0, 1'b1, 8'hFF, TO));
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    channel(0, 0, 8'h00, 1'b0, 1'b0);
    repeat (20) step();
    set_cmd(1, 16'h0044, 48'hD0, 24'h90);
    grant_q.push_back(cmd_rec(1, 16'h0044, 48'hD0, 24'h90));
    grant_q.push_back(cmd_rec(0, 16'h0033, 48'hC0, 24'h80));
    done_q.push_back(done_rec(1, 1'b0, 8'h5A, 3));
    done_q.push_back(done_rec(0, 1'b0, 8'hA5, 1));
    req_valid = 2'b11;
    channel(2, 3, 8'h5A, 1'b1, 1'b0);
    channel(0, 1, 8'hA5, 1'b1, 1'b0);
    req_valid = '0;
    repeat (2) step();

    // i_done during ISSUE is ignored; i_done on the terminal count wins.
    set_cmd(1, 16'h0055, 48'h0000_DEAD_BEEF, 24'h10);
    grant_q.push_back(cmd_rec(1, 16'h0055, 48'h0000_DEAD_BEEF, 24'h10));
    done_q.push_back(done_rec(1, 1'b0, 8'h3C, TO));
    req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    channel(3, TO, 8'h3C, 1'b1, 1'b1);
    repeat (2) step();

    // Reset in WAIT_DONE abandons the command; a later i_done produces nothing.
    set_cmd(0, 16'h0066, 48'h12_3456, 24'h20);
    grant_q.push_back(cmd_rec(0, 16'h0066, 48'h12_3456, 24'h20));
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    channel(1, 0, 8'h00, 1'b0, 1'b0);
    repeat (4) step();
    check("t5_busy_before_rst", o_busy, 1);
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst    = 1'b0;
    i_done = 1'b1;
    i_sr   = 8'h77;
    step();
    i_done = 1'b0;
    repeat (3) step();
    check("t5_idle_after_done", o_busy, 0);
    check("t5_sr_after_done", req_sr, 0);

    // Normal command after reset; requester 1 withdraws before it could be selected.
    set_cmd(0, 16'h0077, 48'h9, 24'h40);
    grant_q.push_back(cmd_rec(0, 16'h0077, 48'h9, 24'h40));
    done_q.push_back(done_rec(0, 1'b0, 8'hC3, 10));
    req_valid[0] = 1'b1;
    step();
    req_valid = 2'b10;
    step();
    step();
    req_valid = '0;
    channel(3, 10, 8'hC3, 1'b1, 1'b0);
    repeat (4) step();

    check("grant_q_empty", grant_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion before limit", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
